soc_rst_seq: RTL
================

// Module: soc_rst_seq
//
// PURPOSE
// Parametrised reset and boot sequencer for SoC tops with several clock-synchronous domains.
// Functions:
//   - Synchronises the async reset deassertion.
//   - Releases NumDomains domain resets one at a time in ascending index order, spaced apart.
//   - Synchronises and glitch-filters fetch enable, plus a bank of generic async inputs.
//   - Supports software-requested re-reset of a subset of domains.
// Sits at the SoC top, between the pads and the core/user domains.
//
// PARAMETERS
// NumDomains    default 2   number of reset outputs (>=1); index 0 is released first
// SyncStages    default 2   synchroniser depth for reset deassertion, fetch_en_i and async_i (>=2)
// ReleaseDelay  default 4   cycles between successive domain releases; also sw reset hold time (>=1)
// FetchFilter   default 4   consecutive synced-high cycles needed before fetch_en_o rises (>=1)
// NumAsyncIn    default 16  width of the generic synchronised input bank (>=1)
//
// PORTS
// clk_i          in   1            system clock
// rst_ni         in   1            async active-low reset
// testmode_i     in   1            1: rst_no[*] = rst_ni combinationally (DFT bypass)
// fetch_en_i     in   1            async boot fetch enable from pad
// async_i        in   NumAsyncIn   async inputs (e.g. GPIO)
// sw_rst_req_i   in   1            1-cycle pulse: re-reset the domains selected by sw_rst_mask_i
// sw_rst_mask_i  in   NumDomains   domain select, sampled when sw_rst_req_i=1
// rst_no         out  NumDomains   per-domain active-low resets
// fetch_en_o     out  1            filtered fetch enable
// async_o        out  NumAsyncIn   synchronised async_i
// seq_done_o     out  1            1 when all domains are out of reset (state RUN)
//
// BEHAVIOUR
// Reset values (rst_ni=0): rst_no=0 (asserted asynchronously, no clock needed), fetch_en_o=0,
//   async_o=0, seq_done_o=0, all sync flops 0, FSM=RESET, counters 0.
// Reset deassertion: internal rst_sync rises on the SyncStages-th clk edge after rst_ni rises.
// Async inputs: async_o = async_i delayed through SyncStages flops. No filtering.
// FSM states:
//   RESET -> RELEASE when rst_sync=1; idx=0, cnt=0.
//   RELEASE: cnt counts 0..ReleaseDelay-1. At cnt==ReleaseDelay-1: set rst_no[idx]=1, cnt=0,
//     advance idx to the next domain due for release. Domain k therefore deasserts
//     ReleaseDelay*(k+1) cycles after rst_sync rises. After the last due domain -> RUN.
//   RUN: seq_done_o=1. sw_rst_req_i=1 with mask!=0 -> SWRST; latch the mask.
//     sw_rst_req_i=1 with mask==0 is ignored.
//   SWRST: on the cycle after the request, rst_no[m]=0 for every latched mask bit m.
//     Hold for ReleaseDelay cycles, then go to RELEASE.
//     RELEASE then visits only the masked domains, in ascending order, with the same spacing.
//     Unmasked domains are skipped at zero cost, and their rst_no stays 1 throughout.
// sw_rst_req_i outside RUN is ignored (no queueing).
// seq_done_o = (state==RUN), registered.
// Fetch enable: fen_sync = fetch_en_i after SyncStages flops.
//   fcnt increments while fen_sync=1, saturating at FetchFilter, and clears on fen_sync=0.
//   fetch_en_o = (fcnt==FetchFilter) & seq_done_o, registered.
//   It falls 1 cycle after fen_sync falls or after seq_done_o falls.
// testmode_i=1: rst_no = {NumDomains{rst_ni}}, bypassing the sequencer; the FSM still runs.
// rst_ni reasserted mid-sequence or mid-SWRST: everything returns to reset values immediately.
// Counter widths: $clog2(max(ReleaseDelay,FetchFilter)+1) and $clog2(NumDomains+1).
//   No wrap is possible.
//
// TESTING
// 1. Defaults, rst_ni 0->1 at edge 0, fetch_en_i=1 held:
//    rst_sync at edge 2, rst_no[0] at edge 6, rst_no[1] at edge 10, seq_done_o at edge 11.
//    fetch_en_o rises at edge 12.
// 2. fetch_en_i glitch high for 3 cycles, then low:
//    fetch_en_o stays 0. A 4-cycle glitch causes a rise only when seq_done_o=1.
// 3. NumDomains=4, in RUN, sw_rst_req_i with mask=4'b1010:
//    rst_no[1] and rst_no[3] go low next cycle. rst_no[0] and rst_no[2] stay 1.
//    fetch_en_o and seq_done_o drop. Releases at +4+4 and +4+8; RUN regained after.
// 4. rst_ni pulsed low during RELEASE (idx=1):
//    all rst_no go 0 with no clock edge. A full sequence restarts after release.
// 5. testmode_i=1: rst_no follows rst_ni combinationally in both directions.
//    sw_rst_req_i has no effect on rst_no.
// 6. async_i=16'hA5C3 applied: async_o=16'hA5C3 after exactly 2 edges.
//    sw_rst_req_i pulses during RELEASE are ignored.

Source files
------------

// File: rtl/soc_rst_seq.sv
// Reset and boot sequencer: synchronises reset release, releases domain resets one by one,
// filters fetch enable, synchronises generic async inputs and supports software re-reset.
module soc_rst_seq #(
    parameter int unsigned NumDomains   = 2,
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned ReleaseDelay = 4,
    parameter int unsigned FetchFilter  = 4,
    parameter int unsigned NumAsyncIn   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  testmode_i,
    input  logic                  fetch_en_i,
    input  logic [NumAsyncIn-1:0] async_i,
    input  logic                  sw_rst_req_i,
    input  logic [NumDomains-1:0] sw_rst_mask_i,
    output logic [NumDomains-1:0] rst_no,
    output logic                  fetch_en_o,
    output logic [NumAsyncIn-1:0] async_o,
    output logic                  seq_done_o
);
    localparam int unsigned MaxCnt = (ReleaseDelay > FetchFilter) ? ReleaseDelay : FetchFilter;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] RelLast = CntW'(ReleaseDelay - 1);
    localparam logic [CntW-1:0] FenMax  = CntW'(FetchFilter);

    typedef enum logic [1:0] {StReset, StRelease, StRun, StSwRst} state_e;

    state_e                                state_q, state_d;
    logic [CntW-1:0]                       cnt_q, cnt_d;
    logic [CntW-1:0]                       fcnt_q, fcnt_d;
    logic [NumDomains-1:0]                 pend_q, pend_d;
    logic [NumDomains-1:0]                 rst_q, rst_d;
    logic [NumDomains-1:0]                 lowest;
    logic                                  done_q, done_d;
    logic                                  fen_q, fen_d;
    logic [SyncStages-2:0]                 rst_sync_q, rst_sync_d;
    logic [SyncStages-1:0]                 fen_sync_q, fen_sync_d;
    logic [SyncStages-1:0][NumAsyncIn-1:0] async_sync_q, async_sync_d;
    logic                                  fen_sync;

    // The FSM state register is the final reset-synchroniser stage: it leaves StReset on the
    // same edge that the synchronised reset deasserts.
    always_comb begin
        rst_sync_d     = '0;
        fen_sync_d     = '0;
        async_sync_d   = '0;
        rst_sync_d[0]  = 1'b1;
        fen_sync_d[0]  = fetch_en_i;
        async_sync_d[0] = async_i;
        for (int i = 1; i < int'(SyncStages) - 1; i++) begin
            rst_sync_d[i] = rst_sync_q[i-1];
        end
        for (int i = 1; i < int'(SyncStages); i++) begin
            fen_sync_d[i]   = fen_sync_q[i-1];
            async_sync_d[i] = async_sync_q[i-1];
        end
    end

    assign fen_sync = fen_sync_q[SyncStages-1];
    // One-hot of the lowest domain still waiting for release.
    assign lowest   = pend_q & (~pend_q + NumDomains'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        rst_d   = rst_q;
        unique case (state_q)
            StReset: begin
                if (rst_sync_q[SyncStages-2]) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                    pend_d  = '1;
                end
            end
            StRelease: begin
                if (cnt_q == RelLast) begin
                    cnt_d  = '0;
                    rst_d  = rst_q | lowest;
                    pend_d = pend_q & ~lowest;
                    if ((pend_q & ~lowest) == '0) begin
                        state_d = StRun;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (sw_rst_req_i && (sw_rst_mask_i != '0)) begin
                    state_d = StSwRst;
                    cnt_d   = '0;
                    pend_d  = sw_rst_mask_i;
                    rst_d   = rst_q & ~sw_rst_mask_i;
                end
            end
            StSwRst: begin
                if (cnt_q == RelLast) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        fcnt_d = '0;
        if (fen_sync) begin
            fcnt_d = (fcnt_q == FenMax) ? fcnt_q : fcnt_q + CntW'(1);
        end
        done_d = (state_q == StRun);
        fen_d  = (fcnt_d == FenMax) & done_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StReset;
            cnt_q        <= '0;
            fcnt_q       <= '0;
            pend_q       <= '0;
            rst_q        <= '0;
            done_q       <= 1'b0;
            fen_q        <= 1'b0;
            rst_sync_q   <= '0;
            fen_sync_q   <= '0;
            async_sync_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fcnt_q       <= fcnt_d;
            pend_q       <= pend_d;
            rst_q        <= rst_d;
            done_q       <= done_d;
            fen_q        <= fen_d;
            rst_sync_q   <= rst_sync_d;
            fen_sync_q   <= fen_sync_d;
            async_sync_q <= async_sync_d;
        end
    end

    // DFT bypass hands the pad reset straight to every domain.
    assign rst_no     = testmode_i ? {NumDomains{rst_ni}} : rst_q;
    assign fetch_en_o = fen_q;
    assign seq_done_o = done_q;
    assign async_o    = async_sync_q[SyncStages-1];

endmodule
